// File: rtl/weight_cfg_pkg.sv
// Shared definitions for the weight/bias configuration loader: header layout,
// FSM states and the header legality check.
package weight_cfg_pkg;

    localparam logic [3:0] KIND_WEIGHT = 4'h1;
    localparam logic [3:0] KIND_BIAS   = 4'h2;

    localparam int KIND_MSB   = 31;
    localparam int KIND_LSB   = 28;
    localparam int LAYER_MSB  = 27;
    localparam int LAYER_LSB  = 20;
    localparam int NEURON_MSB = 19;
    localparam int NEURON_LSB = 12;
    localparam int COUNT_MSB  = 11;
    localparam int COUNT_LSB  = 0;

    localparam int CNT_W = 12;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SKIP,
        GAP,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        HDR_OK,
        HDR_SKIP,
        HDR_ZERO
    } hdr_chk_e;

    // A zero count wins over every other problem: there is nothing to skip.
    function automatic hdr_chk_e check_header(
        input logic [3:0]       kind,
        input logic [7:0]       layer,
        input logic [CNT_W-1:0] count,
        input int unsigned      num_layers,
        input int unsigned      max_weights
    );
        hdr_chk_e res;
        res = HDR_OK;
        if (count == '0)
            res = HDR_ZERO;
        else if (kind != KIND_WEIGHT && kind != KIND_BIAS)
            res = HDR_SKIP;
        else if (32'(layer) >= num_layers)
            res = HDR_SKIP;
        else if (kind == KIND_WEIGHT && 32'(count) > max_weights)
            res = HDR_SKIP;
        else if (kind == KIND_BIAS && count != CNT_W'(1))
            res = HDR_SKIP;
        return res;
    endfunction

endpackage

// File: rtl/weight_config_loader.sv
// Unpacks framed host stream words into per-neuron weight/bias writes.
// One header word selects layer/neuron/kind/count; payload beats follow.
module weight_config_loader
    import weight_cfg_pkg::*;
#(
    parameter int unsigned NUM_LAYERS  = 4,
    parameter int unsigned MAX_WEIGHTS = 784,
    parameter int unsigned WR_GAP      = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        weightValid,
    output logic [31:0] weightValue,
    output logic        biasValid,
    output logic [31:0] biasValue,
    output logic [31:0] config_layer_num,
    output logic [31:0] config_neuron_num,
    output logic        busy,
    output logic        frame_done,
    output logic        frame_err
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       gap_q, gap_d;
    logic             is_bias_q, is_bias_d;
    logic             wv_q, wv_d;
    logic [31:0]      wval_q, wval_d;
    logic             bv_q, bv_d;
    logic [31:0]      bval_q, bval_d;
    logic [7:0]       layer_q, layer_d;
    logic [7:0]       neuron_q, neuron_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             accept;
    logic [3:0]       hdr_kind;
    logic [7:0]       hdr_layer;
    logic [CNT_W-1:0] hdr_count;
    hdr_chk_e         hdr_chk;

    // s_ready is gated by rst so nothing is accepted while reset is held.
    assign s_ready   = rst && (state_q == IDLE || state_q == LOAD || state_q == SKIP);
    assign accept    = s_valid && s_ready;

    assign hdr_kind  = s_data[KIND_MSB:KIND_LSB];
    assign hdr_layer = s_data[LAYER_MSB:LAYER_LSB];
    assign hdr_count = s_data[COUNT_MSB:COUNT_LSB];
    assign hdr_chk   = check_header(hdr_kind, hdr_layer, hdr_count, NUM_LAYERS, MAX_WEIGHTS);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        is_bias_d = is_bias_q;
        wv_d      = 1'b0;
        wval_d    = wval_q;
        bv_d      = 1'b0;
        bval_d    = bval_q;
        layer_d   = layer_q;
        neuron_d  = neuron_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (hdr_chk)
                        HDR_OK: begin
                            layer_d   = hdr_layer;
                            neuron_d  = s_data[NEURON_MSB:NEURON_LSB];
                            is_bias_d = (hdr_kind == KIND_BIAS);
                            cnt_d     = hdr_count;
                            state_d   = LOAD;
                        end
                        HDR_SKIP: begin
                            cnt_d   = hdr_count;
                            state_d = SKIP;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            LOAD: begin
                if (accept) begin
                    if (is_bias_q) begin
                        bv_d   = 1'b1;
                        bval_d = s_data;
                    end else begin
                        wv_d   = 1'b1;
                        wval_d = s_data;
                    end
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end else if (WR_GAP > 0) begin
                        state_d = GAP;
                        gap_d   = 4'(WR_GAP - 1);
                    end
                end
            end
            GAP: begin
                if (gap_q == '0)
                    state_d = LOAD;
                else
                    gap_d = gap_q - 1'b1;
            end
            SKIP: begin
                if (accept) begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            gap_q     <= '0;
            is_bias_q <= 1'b0;
            wv_q      <= 1'b0;
            wval_q    <= '0;
            bv_q      <= 1'b0;
            bval_q    <= '0;
            layer_q   <= '0;
            neuron_q  <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            is_bias_q <= is_bias_d;
            wv_q      <= wv_d;
            wval_q    <= wval_d;
            bv_q      <= bv_d;
            bval_q    <= bval_d;
            layer_q   <= layer_d;
            neuron_q  <= neuron_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign weightValid       = wv_q;
    assign weightValue       = wval_q;
    assign biasValid         = bv_q;
    assign biasValue         = bval_q;
    assign config_layer_num  = {24'd0, layer_q};
    assign config_neuron_num = {24'd0, neuron_q};
    assign busy              = (state_q != IDLE);
    assign frame_done        = done_q;
    assign frame_err         = err_q;

endmodule

// File: tb/tb_weight_config_loader.sv
// Directed bench for weight_config_loader: one instance with WR_GAP=0 and one
// with WR_GAP=2; inputs change and outputs are sampled on the falling edge.
module tb_weight_config_loader;

    logic        clk;
    logic        rst;

    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic        weightValid;
    logic [31:0] weightValue;
    logic        biasValid;
    logic [31:0] biasValue;
    logic [31:0] config_layer_num;
    logic [31:0] config_neuron_num;
    logic        busy;
    logic        frame_done;
    logic        frame_err;

    logic [31:0] g_data;
    logic        g_valid;
    logic        g_ready;
    logic        g_wv;
    logic [31:0] g_wval;
    logic        g_bv;
    logic [31:0] g_bval;
    logic [31:0] g_layer;
    logic [31:0] g_neuron;
    logic        g_busy;
    logic        g_done;
    logic        g_err;

    int errors = 0;
    int checks = 0;

    weight_config_loader #(.NUM_LAYERS(4), .MAX_WEIGHTS(784), .WR_GAP(0)) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .weightValid(weightValid), .weightValue(weightValue),
        .biasValid(biasValid), .biasValue(biasValue),
        .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
        .busy(busy), .frame_done(frame_done), .frame_err(frame_err)
    );

    weight_config_loader #(.NUM_LAYERS(4), .MAX_WEIGHTS(784), .WR_GAP(2)) dut_g (
        .clk(clk), .rst(rst),
        .s_data(g_data), .s_valid(g_valid), .s_ready(g_ready),
        .weightValid(g_wv), .weightValue(g_wval),
        .biasValid(g_bv), .biasValue(g_bval),
        .config_layer_num(g_layer), .config_neuron_num(g_neuron),
        .busy(g_busy), .frame_done(g_done), .frame_err(g_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] gv [3];
        int nstb;
        int nbad;

        gv[0] = 32'h0000_0111;
        gv[1] = 32'h0000_0222;
        gv[2] = 32'h0000_0333;

        rst = 1'b0; s_valid = 1'b0; s_data = '0; g_valid = 1'b0; g_data = '0;
        tick(); tick();

        // Reset state
        check("rst_s_ready", 32'(s_ready), 0);
        check("rst_wv", 32'(weightValid), 0);
        check("rst_bv", 32'(biasValid), 0);
        check("rst_layer", config_layer_num, 0);
        check("rst_neuron", config_neuron_num, 0);
        check("rst_wval", weightValue, 0);
        check("rst_bval", biasValue, 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done_err", {frame_done, frame_err}, 0);
        check("rst_g_ready", 32'(g_ready), 0);
        rst = 1'b1;
        tick();
        check("idle_s_ready", 32'(s_ready), 1);

        // Weight frame: layer 1, neuron 3, 3 words
        s_valid = 1'b1; s_data = 32'h1010_3003;
        tick();
        check("w_layer", config_layer_num, 1);
        check("w_neuron", config_neuron_num, 3);
        check("w_busy", 32'(busy), 1);
        check("w_no_strobe_hdr", 32'(weightValid), 0);
        s_data = 32'hA;
        tick();
        check("w_A", {31'(weightValue), weightValid}, {31'hA, 1'b1});
        s_data = 32'hB;
        tick();
        check("w_B", {31'(weightValue), weightValid}, {31'hB, 1'b1});
        check("w_B_nobias", 32'(biasValid), 0);
        s_data = 32'hC;
        tick();
        check("w_C", {31'(weightValue), weightValid}, {31'hC, 1'b1});
        check("w_done_ready", 32'(s_ready), 0);
        check("w_done_early", 32'(frame_done), 0);
        s_valid = 1'b0;
        tick();
        check("w_frame_done", 32'(frame_done), 1);
        check("w_busy_low", 32'(busy), 0);
        check("w_wv_low", 32'(weightValid), 0);
        check("w_wval_hold", weightValue, 32'hC);
        check("w_layer_hold", config_layer_num, 1);
        tick();
        check("w_done_once", 32'(frame_done), 0);

        // Bias frame: layer 0, neuron 5
        s_valid = 1'b1; s_data = 32'h2000_5001;
        tick();
        check("b_neuron", config_neuron_num, 5);
        check("b_layer", config_layer_num, 0);
        s_data = 32'h0000_1234;
        tick();
        check("b_strobe", 32'(biasValid), 1);
        check("b_value", biasValue, 32'h1234);
        check("b_no_wv", 32'(weightValid), 0);
        s_valid = 1'b0;
        tick();
        check("b_done", 32'(frame_done), 1);
        check("b_bv_low", 32'(biasValid), 0);
        check("b_bval_hold", biasValue, 32'h1234);

        // Illegal kind 3 with 2 payload words, then a good bias frame
        s_valid = 1'b1; s_data = 32'h3000_0002;
        tick();
        check("k3_busy", 32'(busy), 1);
        s_data = 32'hDEAD_0001;
        tick();
        check("k3_no_strobe1", {weightValid, biasValid, frame_err}, 0);
        s_data = 32'hDEAD_0002;
        tick();
        check("k3_err", 32'(frame_err), 1);
        check("k3_no_strobe2", {weightValid, biasValid}, 0);
        check("k3_idle", 32'(busy), 0);
        s_data = 32'h2010_7001;
        tick();
        check("k3_err_once", 32'(frame_err), 0);
        check("k3b_layer", config_layer_num, 1);
        check("k3b_neuron", config_neuron_num, 7);
        s_data = 32'h0000_BEEF;
        tick();
        check("k3b_bias", {biasValid, biasValue}, {1'b1, 32'hBEEF});
        s_valid = 1'b0;
        tick();
        check("k3b_done", 32'(frame_done), 1);

        // Count 0: immediate error, nothing consumed beyond the header
        s_valid = 1'b1; s_data = 32'h1000_0000;
        tick();
        check("c0_err", 32'(frame_err), 1);
        check("c0_idle", {busy, s_ready}, 2'b01);
        s_valid = 1'b0;
        tick();
        check("c0_err_once", 32'(frame_err), 0);

        // Layer 4 is out of range: one word skipped, config nums unchanged
        s_valid = 1'b1; s_data = 32'h1040_0001;
        tick();
        check("l4_busy", 32'(busy), 1);
        check("l4_layer_kept", config_layer_num, 1);
        s_data = 32'h0000_7777;
        tick();
        check("l4_err", {frame_err, weightValid}, 2'b10);
        s_valid = 1'b0;
        tick();

        // Bias with count 2 is rejected
        s_valid = 1'b1; s_data = 32'h2000_1002;
        tick();
        s_data = 32'h1; tick();
        check("bc2_no_strobe", {biasValid, frame_err}, 0);
        s_data = 32'h2; tick();
        check("bc2_err", {frame_err, biasValid}, 2'b10);
        s_valid = 1'b0;
        tick();

        // 784 weights is the largest legal frame
        s_valid = 1'b1; s_data = 32'h1000_0310;
        tick();
        nstb = 0; nbad = 0;
        for (int i = 0; i < 784; i++) begin
            s_data = 32'(i);
            tick();
            nstb += int'(weightValid);
            if (weightValue !== 32'(i)) nbad++;
        end
        s_valid = 1'b0;
        tick();
        check("max_strobes", 32'(nstb), 784);
        check("max_bad_values", 32'(nbad), 0);
        check("max_done", 32'(frame_done), 1);

        // 785 weights is skipped
        s_valid = 1'b1; s_data = 32'h1000_0311;
        tick();
        nstb = 0;
        for (int i = 0; i < 785; i++) begin
            s_data = 32'(i);
            tick();
            nstb += int'(weightValid);
        end
        check("over_err", 32'(frame_err), 1);
        s_valid = 1'b0;
        check("over_strobes", 32'(nstb), 0);
        tick();

        // Host stall: 4 weights, s_valid low for 5 cycles after the 2nd
        s_valid = 1'b1; s_data = 32'h1020_9004;
        tick();
        check("st_layer", config_layer_num, 2);
        check("st_neuron", config_neuron_num, 9);
        s_data = 32'h11; tick();
        check("st_w1", {weightValid, weightValue}, {1'b1, 32'h11});
        s_data = 32'h22; tick();
        check("st_w2", {weightValid, weightValue}, {1'b1, 32'h22});
        s_valid = 1'b0;
        nbad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (weightValid !== 1'b0 || busy !== 1'b1) nbad++;
        end
        check("st_stall", 32'(nbad), 0);
        s_valid = 1'b1; s_data = 32'h33; tick();
        check("st_w3", {weightValid, weightValue}, {1'b1, 32'h33});
        s_data = 32'h44; tick();
        check("st_w4", {weightValid, weightValue}, {1'b1, 32'h44});
        s_valid = 1'b0;
        tick();
        check("st_done", 32'(frame_done), 1);

        // Reset after the 2nd of 4 weights, then a fresh bias frame
        s_valid = 1'b1; s_data = 32'h1030_2004;
        tick();
        s_data = 32'h91; tick();
        s_data = 32'h92; tick();
        check("rm_w2", {weightValid, weightValue}, {1'b1, 32'h92});
        rst = 1'b0; s_valid = 1'b0;
        #1;
        check("rm_ready_in_rst", 32'(s_ready), 0);
        tick();
        check("rm_outs", {s_ready, weightValid, biasValid, busy, frame_done, frame_err}, 0);
        check("rm_vals", weightValue | biasValue | config_layer_num | config_neuron_num, 0);
        rst = 1'b1;
        s_valid = 1'b1; s_data = 32'h2020_4001;
        tick();
        check("rm_hdr", {config_layer_num[7:0], config_neuron_num[7:0]}, 16'h0204);
        s_data = 32'h55; tick();
        check("rm_bias", {biasValid, biasValue}, {1'b1, 32'h55});
        s_valid = 1'b0;
        tick();
        check("rm_done", 32'(frame_done), 1);

        // WR_GAP = 2: ready low two cycles after each non-final beat
        g_valid = 1'b1; g_data = 32'h1000_1003;
        tick();
        check("g_busy", 32'(g_busy), 1);
        g_data = gv[0];
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("g_w%0d", i), {g_wv, g_wval}, {1'b1, gv[i]});
            check($sformatf("g_rdy_lo_a%0d", i), 32'(g_ready), 0);
            if (i < 2) begin
                g_data = gv[i + 1];
                tick();
                check($sformatf("g_rdy_lo_b%0d", i), {g_ready, g_wv}, 0);
                tick();
                check($sformatf("g_rdy_hi%0d", i), {g_ready, g_wv}, 2'b10);
            end
        end
        g_valid = 1'b0;
        tick();
        check("g_done", 32'(g_done), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/weight_config_loader.md
Name: weight_config_loader

Overview:
- Initiator side of the neuron weight/bias configuration interface: drives weightValid/weightValue, biasValid/biasValue, config_layer_num and config_neuron_num into the neuron array.
- Consumes a framed 32-bit valid/ready stream from the host-side DMA and unpacks each frame into targeted writes.
- Sits between the host stream and all neuron instances of all layers; one instance per network.

Parameters:
- NUM_LAYERS, 4, number of layers; layer field values >= NUM_LAYERS are rejected.
- MAX_WEIGHTS, 784, largest legal weight count per frame.
- WR_GAP, 0, idle cycles forced between consecutive payload beats (s_ready low), 0..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-low
- s_data  in  32  host stream word
- s_valid  in  1  host word valid
- s_ready  out  1  loader accepts word when s_valid & s_ready
- weightValid  out  1  one-cycle strobe per weight word
- weightValue  out  32  weight word, valid with weightValid
- biasValid  out  1  one-cycle strobe for the bias word
- biasValue  out  32  bias word, valid with biasValid
- config_layer_num  out  32  target layer, zero-extended
- config_neuron_num  out  32  target neuron, zero-extended
- busy  out  1  high from header accept until the frame ends
- frame_done  out  1  one-cycle pulse after the last payload beat of a good frame
- frame_err  out  1  one-cycle pulse when a frame is rejected

Behaviour:
- Header word fields: [31:28] kind (1 = weight, 2 = bias); [27:20] layer; [19:12] neuron; [11:0] count of payload words that follow.
- Reset (rst == 0): state IDLE. All outputs 0, including s_ready, config nums, values and strobes. Beat, gap and error flags cleared.
- A reset mid-frame abandons the frame. Any remaining payload words are then parsed as headers; host recovery is the host's responsibility.
- States: IDLE, LOAD, SKIP, GAP, DONE.
- IDLE:
  - s_ready = 1. On header accept, the header is checked.
  - Legal header: config_layer_num and config_neuron_num are registered on the next edge; busy = 1; beat counter = count; go to LOAD.
  - Illegal header:
    - kind not 1 or 2 -> go to SKIP.
    - layer >= NUM_LAYERS -> go to SKIP.
    - kind 1 with count > MAX_WEIGHTS -> go to SKIP.
    - kind 2 with count != 1 -> go to SKIP.
    - count == 0 (any kind): pulse frame_err next cycle and stay in IDLE.
  - SKIP with a zero count is never entered.
- LOAD:
  - s_ready = 1. Each accepted beat registers its value next cycle with a one-cycle strobe: weightValid/weightValue for kind 1, biasValid/biasValue for kind 2. Latency from accept to strobe is 1 cycle.
  - The beat counter decrements per beat.
  - On the last beat go to DONE. Otherwise go to GAP if WR_GAP > 0, else stay in LOAD.
- GAP: s_ready = 0 for exactly WR_GAP cycles, then return to LOAD.
- SKIP:
  - s_ready = 1. The count payload beats are accepted and discarded; no strobes are issued.
  - After the last discarded beat: frame_err pulses 1 cycle, then go to IDLE.
- DONE (1 cycle):
  - s_ready = 0. The last strobe is visible this cycle.
  - frame_done pulses on the following cycle, together with the return to IDLE.
  - busy deasserts on entering IDLE.
- config_layer_num and config_neuron_num stay stable from header+1 until the next legal header; they are not cleared at frame end. This guarantees the target neuron sees them with its final strobe.
- weightValue and biasValue hold their last value when the strobe is low.
- s_valid low in LOAD or SKIP stalls the frame; there is no timeout.
- The beat counter is 12 bits and never wraps: it is loaded only with a checked count, and SKIP decrements only to 0.
- weightValid and biasValid are never high in the same cycle.

Decomposition:
- Package weight_cfg_pkg holds:
  - KIND_WEIGHT = 4'h1 and KIND_BIAS = 4'h2
  - header field MSB/LSB constants
  - state enum {IDLE, LOAD, SKIP, GAP, DONE}
  - the 12-bit count width constant
- Single module, no sub-module: the header decode/check is a small combinational function in the package.

Test Plan:
- Weight frame: header 0x1_01_03_003 then payloads 0xA, 0xB, 0xC, s_valid continuous, WR_GAP = 0 -> config_layer_num = 1 and config_neuron_num = 3 from header+1; weightValid high 3 consecutive cycles with values A, B, C, each 1 cycle after accept; frame_done pulse once; busy low afterwards.
- Bias frame: header 0x2_00_05_001 then payload 0x0000_1234 -> single biasValid with biasValue 0x1234; config_neuron_num = 5; no weightValid.
- WR_GAP = 2 with 3 weights -> s_ready low exactly 2 cycles after each of the first two payload beats; the three weightValid strobes are spaced 3 cycles apart.
- Illegal frames:
  - kind 3, count 2, followed by a good bias frame -> 2 words swallowed with no strobes; frame_err pulses once; the following bias frame loads normally.
  - count 0 -> frame_err with no beats consumed.
- Host stall: s_valid drops for 5 cycles after the 2nd of 4 weights -> no strobes during the stall; busy stays high; the remaining 2 weights arrive correctly.
- Reset mid-frame: rst low for 1 cycle after the 2nd of 4 weights -> all outputs 0, s_ready 0 during reset; the next header is accepted and decoded correctly.
